io_input: RTL and testbench
===========================

Name: io_input

Overview:
- Input-side counterpart of the CPU's character output port: buffers bytes from an external byte source and serves them to the subleq core's input read.
- Reads are one word per `in_read` strobe: the zero-extended byte when data is buffered, the EOF word (all ones, i.e. -1) when the buffer is empty.
- Sits between the testbench/host byte source (valid/ready handshake) and the core's IO address decode.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock.
- areset  input  1  reset; synchronous, active-high.
- src_valid  input  1  source offers `src_data` this cycle.
- src_data  input  8  byte from source.
- src_ready  output  1  block accepts a byte this cycle.
- in_read  input  1  core consumes the current `io_in` value this cycle.
- io_in  output  `WORD_SIZE  current input word: head byte zero-extended, or all ones when empty.
- in_avail  output  1  FIFO non-empty.
- count  output  ADDR_W+1  number of buffered bytes, 0..DEPTH.
- in_underrun  output  1  sticky flag: `in_read` was asserted while empty.

Behaviour:
- All state is on posedge clk. `areset` high at a clock edge:
  - clears read/write pointers, `count`, `in_underrun` and the CR state;
  - FIFO contents need not be cleared.
- Outputs after reset: `count`=0, `in_avail`=0, `src_ready`=1, `in_underrun`=0, `io_in`=all ones.
- Reset mid-stream discards all buffered bytes. A handshake in the reset cycle is ignored.
- Push:
  - A byte is accepted when `src_valid && src_ready`.
  - `src_ready` = (`count` != DEPTH), registered-state only, with no combinational path from `in_read`.
  - When full, no push occurs, even if a pop happens in the same cycle.
- Pop: occurs when `in_read && in_avail`; the read pointer advances.
- `io_in`:
  - Combinational from registered state: mem[rd_ptr] zero-extended to `WORD_SIZE` when non-empty, else all ones.
  - A pushed byte becomes visible on `io_in` the cycle after acceptance (1-cycle latency).
  - Bypass from `src_data` to `io_in` is forbidden.
- Simultaneous push and pop (non-empty, non-full): both occur and `count` is unchanged.
- Push into empty with `in_read` in the same cycle: `io_in` shows EOF, no pop occurs, and `in_underrun` sets. The pushed byte appears next cycle.
- `in_read` while empty: `count` and pointers are unchanged and `in_underrun` sets to 1. It stays set until `areset`.
- Pointers are ADDR_W bits and wrap modulo DEPTH. `count` is an ADDR_W+1-bit up/down counter.
- A byte value of 0xFF is delivered as 0x00FF-style zero-extended data, distinct from EOF.

Optional Feature:
- Macro: `IO_INPUT_CRLF_EN`.
- Defined: line-ending normalisation on the push side.
  - An accepted 0x0D is stored as 0x0A and sets a `last_cr` state bit.
  - An accepted 0x0A with `last_cr`=1 is consumed (`src_ready` honoured as normal) but not stored.
  - Any accepted byte other than 0x0D clears `last_cr`.
  - A lone LF, or LF following any other byte, is stored unchanged.
  - `last_cr` clears on `areset`.
  - When full, the handshake does not complete and `last_cr` is unchanged.
- Undefined: bytes are stored verbatim; no `last_cr` logic.

Decomposition:
- `defines.vh` holds:
  - `WORD_SIZE`;
  - `IO_EOF` (all-ones word);
  - `ASCII_CR` (8'h0D) and `ASCII_LF` (8'h0A).
- One sub-module, `io_fifo`: synchronous FIFO parameterised by width (8) and DEPTH.
  - Ports: push/pop/data/full/empty/count.
  - `io_input` wraps it with the EOF mux, underrun flag and optional CRLF filter.

Test Plan:
- Reset, then idle → `io_in`=all ones, `in_avail`=0, `count`=0, `src_ready`=1. Then `in_read` 1 cycle → `in_underrun`=1, `count` still 0.
- Push 0x41, 0x42, 0xFF → `count`=3; `io_in`=0x41 the cycle after the first push. Three `in_read` strobes yield 0x41, 0x42, 0x00FF, then EOF (all ones) with `in_avail`=0.
- Fill to 16 with 0x00..0x0F → `src_ready`=0, and a 17th `src_valid` is not accepted.
  - `in_read` + `src_valid`(0x10) in the same cycle while full → pop only, `count`=15.
  - Next cycle: push accepted, `count`=16.
- Steady state at `count`=5: push + pop every cycle for 40 cycles (pointer wrap) → `count` stays 5 and data order is preserved.
- Push 3 bytes, assert `areset` for 1 cycle with `src_valid` high → `count`=0, `io_in`=EOF, `in_underrun`=0.
- With `IO_INPUT_CRLF_EN`: push 0x0D, 0x0A, 0x0A, 0x41, 0x0D → read sequence 0x0A, 0x0A, 0x41, 0x0A, then EOF; all 5 handshakes completed.

Source files
------------

// File: rtl/io_input_pkg.sv
// Package for the io_input block: byte width, default FIFO geometry and the
// helper that widens a buffered byte to a core word.
`include "defines.vh"

package io_input_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_AW    = 4;

  // A byte is always delivered zero-extended, so 8'hFF can never be
  // confused with the all-ones EOF word.
  function automatic logic [`WORD_SIZE-1:0] zext_byte(input logic [BYTE_W-1:0] b);
    return {{(`WORD_SIZE - BYTE_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/defines.vh
// Shared macros for the io_input block.
//   WORD_SIZE : width of the core's data word
//   IO_EOF    : word returned on an input read when no byte is buffered (-1)
//   ASCII_CR  : carriage return byte
//   ASCII_LF  : line feed byte
`ifndef IO_INPUT_DEFINES_VH
`define IO_INPUT_DEFINES_VH

`define WORD_SIZE 16
`define IO_EOF    {`WORD_SIZE{1'b1}}
`define ASCII_CR  8'h0D
`define ASCII_LF  8'h0A

`endif

// File: rtl/io_fifo.sv
// Synchronous FIFO used as the input byte buffer.
// Ports:
//   clk, areset       : clock, synchronous active-high reset
//   push, wr_data     : write request and data (ignored when full)
//   pop               : read request (ignored when empty)
//   rd_data           : head entry, valid while !empty
//   full, empty, count: occupancy status, count in 0..DEPTH
module io_fifo
  import io_input_pkg::*;
#(
  parameter int WIDTH  = BYTE_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_AW
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are ADDR_W bits wide, so +1 wraps modulo DEPTH for free.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/io_input.sv
// io_input: buffers bytes from an external source (valid/ready) and serves
// them one word per in_read strobe to the core; EOF (all ones) when empty.
// Ports:
//   clk, areset          : clock, synchronous active-high reset
//   src_valid, src_data  : byte offered by the source
//   src_ready            : a byte is accepted this cycle if src_valid
//   in_read              : core consumes io_in this cycle
//   io_in                : head byte zero-extended, or EOF when empty
//   in_avail             : buffer non-empty
//   count                : buffered bytes, 0..DEPTH
//   in_underrun          : sticky, in_read seen while empty
// Optional feature macro: IO_INPUT_CRLF_EN -- when defined, CR is stored as
// LF and an LF immediately following an accepted CR is swallowed.
`include "defines.vh"

module io_input
  import io_input_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_AW
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  src_valid,
  input  logic [7:0]            src_data,
  output logic                  src_ready,
  input  logic                  in_read,
  output logic [`WORD_SIZE-1:0] io_in,
  output logic                  in_avail,
  output logic [ADDR_W:0]       count,
  output logic                  in_underrun
);

  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_wr_data;
  logic [7:0]       fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             underrun_q, underrun_d;

  // src_ready depends only on registered occupancy, never on in_read.
  assign src_ready = !fifo_full;
  // A handshake coinciding with reset is dropped.
  assign accept    = src_valid && src_ready && !areset;
  assign fifo_pop  = in_read && !fifo_empty;

`ifdef IO_INPUT_CRLF_EN
  logic last_cr_q, last_cr_d;
  logic drop_lf;

  // LF directly after CR completes its handshake but is not stored.
  assign drop_lf      = (src_data == `ASCII_LF) && last_cr_q;
  assign fifo_push    = accept && !drop_lf;
  assign fifo_wr_data = (src_data == `ASCII_CR) ? `ASCII_LF : src_data;

  always_comb begin
    last_cr_d = last_cr_q;
    if (accept) last_cr_d = (src_data == `ASCII_CR);
  end

  always_ff @(posedge clk) begin
    if (areset) last_cr_q <= 1'b0;
    else        last_cr_q <= last_cr_d;
  end
`else
  assign fifo_push    = accept;
  assign fifo_wr_data = src_data;
`endif

  always_comb begin
    underrun_d = underrun_q;
    if (in_read && fifo_empty) underrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (areset) underrun_q <= 1'b0;
    else        underrun_q <= underrun_d;
  end

  io_fifo #(
    .WIDTH  (8),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .areset  (areset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // Purely from registered state: no bypass from src_data.
  assign io_in       = fifo_empty ? `IO_EOF : zext_byte(fifo_rd_data);
  assign in_avail    = !fifo_empty;
  assign in_underrun = underrun_q;

endmodule

// File: tb/tb_io_input.sv
// Self-checking bench for io_input: directed steps, with a scoreboard queue
// of expected bytes filled on accepted pushes and drained on reads.
module tb_io_input;

  localparam int DEPTH = 16;
  localparam int W     = 16;
  localparam logic [W-1:0] EOF_W = '1;

  logic         clk;
  logic         areset;
  logic         src_valid;
  logic [7:0]   src_data;
  logic         src_ready;
  logic         in_read;
  logic [W-1:0] io_in;
  logic         in_avail;
  logic [4:0]   count;
  logic         in_underrun;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sb_q [$];
  bit         m_under = 0;
  bit         m_last_cr = 0;

  io_input #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk         (clk),
    .areset      (areset),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .in_read     (in_read),
    .io_in       (io_in),
    .in_avail    (in_avail),
    .count       (count),
    .in_underrun (in_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model, then apply one clock of stimulus.
  task automatic cycle(input bit v, input logic [7:0] d, input bit rd);
    bit acc;
    int n;
    src_valid = v;
    src_data  = d;
    in_read   = rd;
    n = sb_q.size();
    check("src_ready",   32'(src_ready),   32'(n != DEPTH));
    check("count",       32'(count),       32'(n));
    check("in_avail",    32'(in_avail),    32'(n != 0));
    check("in_underrun", 32'(in_underrun), 32'(m_under));
    check("io_in",       32'(io_in),       (n != 0) ? {24'h0, sb_q[0]} : 32'(EOF_W));
    acc = v && (n != DEPTH);
    if (rd && n != 0) void'(sb_q.pop_front());
    else if (rd)      m_under = 1'b1;
    if (acc) begin
`ifdef IO_INPUT_CRLF_EN
      if (d == 8'h0D)                    sb_q.push_back(8'h0A);
      else if (!(d == 8'h0A && m_last_cr)) sb_q.push_back(d);
      m_last_cr = (d == 8'h0D);
`else
      sb_q.push_back(d);
`endif
    end
    @(posedge clk);
    #1;
    src_valid = 1'b0;
    in_read   = 1'b0;
  endtask

  task automatic do_reset(input bit with_valid);
    areset    = 1'b1;
    src_valid = with_valid;
    src_data  = 8'h55;
    in_read   = 1'b0;
    @(posedge clk);
    #1;
    areset    = 1'b0;
    src_valid = 1'b0;
    sb_q.delete();
    m_under   = 1'b0;
    m_last_cr = 1'b0;
  endtask

  initial begin
    areset    = 1'b1;
    src_valid = 1'b0;
    src_data  = 8'h00;
    in_read   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Reset state.
    check("rst_io_in",     32'(io_in),       32'(EOF_W));
    check("rst_in_avail",  32'(in_avail),    32'd0);
    check("rst_count",     32'(count),       32'd0);
    check("rst_src_ready", 32'(src_ready),   32'd1);
    check("rst_underrun",  32'(in_underrun), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    check("underrun_set",   32'(in_underrun), 32'd1);
    check("underrun_count", 32'(count),       32'd0);
    cycle(1'b0, 8'h00, 1'b0);
    check("underrun_sticky", 32'(in_underrun), 32'd1);

    // Basic pushes, including 0xFF distinct from EOF.
    do_reset(1'b0);
    cycle(1'b1, 8'h41, 1'b0);
    check("first_visible", 32'(io_in), 32'h0041);
    cycle(1'b1, 8'h42, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    check("count_three", 32'(count), 32'd3);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("ff_zext", 32'(io_in), 32'h00FF);
    cycle(1'b0, 8'h00, 1'b1);
    check("drained_eof",   32'(io_in),    32'(EOF_W));
    check("drained_avail", 32'(in_avail), 32'd0);
    check("no_underrun",   32'(in_underrun), 32'd0);

    // Push into empty with in_read in the same cycle: no pop, underrun sets.
    cycle(1'b1, 8'h33, 1'b1);
    check("push_rd_empty_io",  32'(io_in),       32'h0033);
    check("push_rd_empty_und", 32'(in_underrun), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // Fill to full.
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    check("full_ready", 32'(src_ready), 32'd0);
    check("full_count", 32'(count),     32'd16);
    cycle(1'b1, 8'h10, 1'b0);
    check("full_no_push", 32'(count), 32'd16);
    cycle(1'b1, 8'h10, 1'b1);
    check("full_pop_only", 32'(count), 32'd15);
    check("full_pop_head", 32'(io_in), 32'h0001);
    cycle(1'b1, 8'h10, 1'b0);
    check("refill_count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    check("full_drained", 32'(io_in), 32'(EOF_W));

    // Steady state at five entries with pointer wrap.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 5; i < 45; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1);
    check("steady_count", 32'(count), 32'd5);
    check("steady_head",  32'(io_in), 32'h00A8);

    // Reset mid-stream with a handshake in the reset cycle.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1);
    do_reset(1'b1);
    check("midrst_count", 32'(count),       32'd0);
    check("midrst_io_in", 32'(io_in),       32'(EOF_W));
    check("midrst_under", 32'(in_underrun), 32'd0);
    cycle(1'b0, 8'h00, 1'b0);

`ifdef IO_INPUT_CRLF_EN
    // CR/LF normalisation.
    do_reset(1'b0);
    cycle(1'b1, 8'h0D, 1'b0);
    cycle(1'b1, 8'h0A, 1'b0);
    cycle(1'b1, 8'h0A, 1'b0);
    cycle(1'b1, 8'h41, 1'b0);
    cycle(1'b1, 8'h0D, 1'b0);
    check("crlf_count", 32'(count), 32'd4);
    check("crlf_head",  32'(io_in), 32'h000A);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    check("crlf_eof", 32'(io_in), 32'(EOF_W));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
